// File: rtl/obi_resp_model.sv
// Nondeterministic OBI slave responder for formal harnesses: solver-driven grant/response
// with in-order, depth-limited transaction queue and a sticky master-protocol monitor.
module obi_resp_model #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  input  logic              nd_gnt_i,
  input  logic              nd_rvalid_i,
  input  logic [DATA_W-1:0] nd_rdata_i,
  input  logic              nd_err_i,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic              rsp_we_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              proto_err_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              pend_q, pend_d;
  logic              proto_err_q, proto_err_d;

  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [DEPTH];
  logic              mem_we_q   [DEPTH];
  logic              mem_we_d   [DEPTH];
  logic [BE_W-1:0]   mem_be_q   [DEPTH];
  logic [BE_W-1:0]   mem_be_d   [DEPTH];
  logic [DATA_W-1:0] mem_wdata_q[DEPTH];
  logic [DATA_W-1:0] mem_wdata_d[DEPTH];

  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic              cap_we_q, cap_we_d;
  logic [BE_W-1:0]   cap_be_q, cap_be_d;
  logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;

  logic push, pop, hold, viol, not_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant and response decisions look only at registered count, never at each other
  assign not_empty     = (count_q != '0);
  assign gnt_o         = !reset && req_i && nd_gnt_i && (count_q < DEPTH_C);
  assign rvalid_o      = !reset && not_empty && nd_rvalid_i;
  assign push          = gnt_o;
  assign pop           = rvalid_o;
  assign rsp_addr_o    = not_empty ? mem_addr_q[rd_ptr_q] : '0;
  assign rsp_we_o      = not_empty ? mem_we_q[rd_ptr_q] : 1'b0;
  assign rdata_o       = (rvalid_o && !mem_we_q[rd_ptr_q]) ? nd_rdata_i : '0;
  assign err_o         = rvalid_o && nd_err_i;
  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if (push) begin
      mem_addr_d[wr_ptr_q]  = addr_i;
      mem_we_d[wr_ptr_q]    = we_i;
      mem_be_d[wr_ptr_q]    = be_i;
      mem_wdata_d[wr_ptr_q] = wdata_i;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A held (ungranted) request must reappear unchanged next cycle
  always_comb begin
    hold = req_i && !gnt_o;
    viol = pend_q && (!req_i || (addr_i != cap_addr_q) || (we_i != cap_we_q) ||
                      (be_i != cap_be_q) || (we_i && (wdata_i != cap_wdata_q)));
    proto_err_d = proto_err_q || viol;
    pend_d      = hold;
    cap_addr_d  = hold ? addr_i  : cap_addr_q;
    cap_we_d    = hold ? we_i    : cap_we_q;
    cap_be_d    = hold ? be_i    : cap_be_q;
    cap_wdata_d = hold ? wdata_i : cap_wdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pend_q      <= pend_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Payload storage is only observed through valid control state, so it carries no reset
  always_ff @(posedge clock) begin
    mem_addr_q  <= mem_addr_d;
    mem_we_q    <= mem_we_d;
    mem_be_q    <= mem_be_d;
    mem_wdata_q <= mem_wdata_d;
    cap_addr_q  <= cap_addr_d;
    cap_we_q    <= cap_we_d;
    cap_be_q    <= cap_be_d;
    cap_wdata_q <= cap_wdata_d;
  end
endmodule
